ahb2apb_bridge_n: RTL and testbench

Parametrised AHB-Lite to APB4 bridge: one AHB-Lite slave port fanned out to `NSLV` APB slaves through a fixed address map. Beyond a basic single-slave bridge it adds:
- multi-slave decode with a decode-error response;
- byte strobes generated from HSIZE;
- PSLVERR propagation to HRESP;
- a PREADY watchdog timeout.

It sits between the AHB master/driver side and the APB peripheral cluster of the AHB2APB verification environment.

---
 rtl/ahb_apb_pkg.sv | 37 +++
 rtl/ahb2apb_decode.sv | 31 +++
 rtl/ahb2apb_bridge_n.sv | 145 ++++++++++++++
 tb/tb_ahb2apb_bridge_n.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared encodings and helpers for the AHB-Lite to APB4 bridge
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Byte lanes touched by a transfer; sized for the widest (64-bit) bus.
  function automatic logic [7:0] size2strb(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [7:0] mask;
    case (size)
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0f;
      default: mask = 8'hff;
    endcase
    return mask << addr_lo;
  endfunction

  function automatic logic size_ok(input logic [2:0] size, input int dw);
    return int'(size) <= $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/ahb2apb_decode.sv
// rtl/ahb2apb_decode.sv - address map decode: slave index and transfer legality
module ahb2apb_decode
  import ahb_apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            NSLV      = 4,
  parameter logic [AW-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int            SPAN_LOG2 = 12,
  parameter int            IW        = 2
) (
  input  logic [AW-1:0] HADDR,
  input  logic [2:0]    HSIZE,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [AW-1:0] offset;
  logic [AW-1:0] slot;
  logic [AW-1:0] size_mask;

  always_comb begin
    offset    = HADDR - BASE_ADDR;
    slot      = offset >> SPAN_LOG2;
    size_mask = (AW'(1) << HSIZE) - AW'(1);
    idx       = slot[IW-1:0];
    valid     = (HADDR >= BASE_ADDR) && (slot < AW'(NSLV)) &&
                size_ok(HSIZE, DW) && ((HADDR & size_mask) == '0);
  end

endmodule

// File: rtl/ahb2apb_bridge_n.sv
// rtl/ahb2apb_bridge_n.sv - AHB-Lite slave fanned out to NSLV APB4 slaves
module ahb2apb_bridge_n
  import ahb_apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            NSLV      = 4,
  parameter logic [AW-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int            SPAN_LOG2 = 12,
  parameter int            TIMEOUT   = 16
) (
  input  logic                 CLK,
  input  logic                 HRESET,
  input  logic [AW-1:0]        HADDR,
  input  logic                 HWRITE,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [DW-1:0]        HWDATA,
  input  logic                 HREADY_IN,
  output logic                 HREADY_OUT,
  output logic [DW-1:0]        HRDATA,
  output logic [1:0]           HRESP,
  output logic [AW-1:0]        PADDR,
  output logic                 PWRITE,
  output logic [NSLV-1:0]      PSEL,
  output logic                 PENABLE,
  output logic [DW-1:0]        PWDATA,
  output logic [DW/8-1:0]      PSTRB,
  input  logic [NSLV*DW-1:0]   PRDATA,
  input  logic [NSLV-1:0]      PREADY,
  input  logic [NSLV-1:0]      PSLVERR
);

  localparam int BW = $clog2(DW / 8);
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] dec_idx;
  logic          dec_valid;
  logic [CW-1:0] wd_cnt;
  logic [2:0]    addr_lo;
  logic [7:0]    strb8;
  logic          pready_s;
  logic          pslverr_s;
  logic [DW-1:0] prdata_s;
  logic          done_ok;
  logic          accept;
  logic          wd_expire;
  logic          unused_ok;

  ahb2apb_decode #(
    .AW(AW), .DW(DW), .NSLV(NSLV), .BASE_ADDR(BASE_ADDR),
    .SPAN_LOG2(SPAN_LOG2), .IW(IW)
  ) u_decode (
    .HADDR (HADDR),
    .HSIZE (HSIZE),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  assign unused_ok = ^{HBURST, strb8};

  always_comb begin
    addr_lo          = '0;
    addr_lo[BW-1:0]  = HADDR[BW-1:0];
    strb8            = size2strb(HSIZE, addr_lo);
    pready_s         = PREADY[idx_q];
    pslverr_s        = PSLVERR[idx_q];
    prdata_s         = PRDATA[idx_q*DW +: DW];
    done_ok          = (state == ST_ACCESS) && pready_s && !pslverr_s;
    // A new transfer may only be taken in a cycle where we drive HREADY_OUT high.
    accept           = (state == ST_IDLE || state == ST_ERR2 || done_ok) && HREADY_IN &&
                       (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    wd_expire        = (TIMEOUT != 0) && (int'(wd_cnt) >= TIMEOUT - 1);
    HREADY_OUT       = (state == ST_IDLE) || (state == ST_ERR2) || done_ok;
    HRESP            = ((state == ST_ERR1) || (state == ST_ERR2) ||
                        ((state == ST_ACCESS) && pready_s && pslverr_s)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA           = done_ok ? prdata_s : '0;
  end

  always_ff @(posedge CLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      wd_cnt  <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      case (state)
        ST_WWAIT: begin
          PWDATA <= HWDATA;
          PSEL   <= NSLV'(1) << idx_q;
          wd_cnt <= '0;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_s) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= pslverr_s ? ST_ERR2 : ST_IDLE;
          end else if (wd_expire) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= ST_ERR1;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase

      // Accept overrides the completion path so back-to-back beats need no IDLE gap.
      if (accept) begin
        if (!dec_valid) begin
          state <= ST_ERR1;
        end else begin
          PADDR  <= HADDR;
          PWRITE <= HWRITE;
          PSTRB  <= HWRITE ? strb8[DW/8-1:0] : '0;
          idx_q  <= dec_idx;
          wd_cnt <= '0;
          if (HWRITE) begin
            state <= ST_WWAIT;
          end else begin
            PSEL  <= NSLV'(1) << dec_idx;
            state <= ST_SETUP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_n.sv
// tb/tb_ahb2apb_bridge_n.sv - directed-vector bench for ahb2apb_bridge_n
module tb_ahb2apb_bridge_n;

  logic          CLK;
  logic          HRESET;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [31:0]   HWDATA;
  logic          HREADY_IN;
  logic          HREADY_OUT;
  logic [31:0]   HRDATA;
  logic [1:0]    HRESP;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic [3:0]    PSEL;
  logic          PENABLE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [127:0]  PRDATA;
  logic [3:0]    PREADY;
  logic [3:0]    PSLVERR;

  int vectors;
  int miscompares;

  ahb2apb_bridge_n #(
    .AW(32), .DW(32), .NSLV(4), .BASE_ADDR(32'h4000_0000), .SPAN_LOG2(12), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .HRESET(HRESET), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY_IN(HREADY_IN),
    .HREADY_OUT(HREADY_OUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    HTRANS    = 2'b00;
    HADDR     = 32'h0;
    HWRITE    = 1'b0;
    HSIZE     = 3'd0;
    HREADY_IN = 1'b1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
    HADDR     = a;
    HWRITE    = w;
    HSIZE     = s;
    HTRANS    = 2'b10;
    HREADY_IN = 1'b1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus_idle();
    repeat (2) step();
    #2;
    vectors++;
    if ({HREADY_OUT, HRESP, HRDATA} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_ahb: got %h want %h", {HREADY_OUT, HRESP, HRDATA}, {1'b1, 2'b00, 32'h0});
    end
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PSTRB} !== 10'h0) begin
      miscompares++;
      $display("FAIL rst_apb_ctl: got %h want %h", {PSEL, PENABLE, PWRITE, PSTRB}, 10'h0);
    end
    vectors++;
    if ({PADDR, PWDATA} !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_apb_data: got %h want %h", {PADDR, PWDATA}, 64'h0);
    end
    HRESET = 1'b0;
  endtask

  task automatic test_read();
    step();
    addr_phase(32'h4000_1004, 1'b0, 3'd2);
    PSLVERR = 4'b1101;
    #2;
    vectors++;
    if (HREADY_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_accept: got %b want 1", HREADY_OUT);
    end
    step();
    bus_idle();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT} !== {4'b0010, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rd_setup: got %b want %b", {PSEL, PENABLE, HREADY_OUT}, {4'b0010, 1'b0, 1'b0});
    end
    vectors++;
    if ({PADDR, PWRITE, PSTRB} !== {32'h4000_1004, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL rd_addr: got %h want %h", {PADDR, PWRITE, PSTRB}, {32'h4000_1004, 1'b0, 4'b0000});
    end
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA} !== {4'b0010, 1'b1, 1'b1, 2'b00, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL rd_access: got %h want %h", {PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA},
               {4'b0010, 1'b1, 1'b1, 2'b00, 32'hCAFE_F00D});
    end
    step();
    PSLVERR = 4'b0000;
    #2;
    vectors++;
    if ({PSEL, PENABLE, HRDATA} !== 37'h0) begin
      miscompares++;
      $display("FAIL rd_done: got %h want %h", {PSEL, PENABLE, HRDATA}, 37'h0);
    end
  endtask

  task automatic test_write_wait();
    step();
    addr_phase(32'h4000_2003, 1'b1, 3'd0);
    #2;
    step();
    bus_idle();
    HWDATA = 32'hAB00_0000;
    PREADY = 4'b1011;
    #2;
    vectors++;
    if ({PSEL, HREADY_OUT} !== 5'b0) begin
      miscompares++;
      $display("FAIL wr_wwait: got %b want %b", {PSEL, HREADY_OUT}, 5'b0);
    end
    step();
    HWDATA = 32'h5555_5555;
    #2;
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PSTRB, PWDATA} !== {4'b0100, 1'b0, 1'b1, 4'b1000, 32'hAB00_0000}) begin
      miscompares++;
      $display("FAIL wr_setup: got %h want %h", {PSEL, PENABLE, PWRITE, PSTRB, PWDATA},
               {4'b0100, 1'b0, 1'b1, 4'b1000, 32'hAB00_0000});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      vectors++;
      if ({PSEL, PENABLE, HREADY_OUT, PWDATA} !== {4'b0100, 1'b1, 1'b0, 32'hAB00_0000}) begin
        miscompares++;
        $display("FAIL wr_wait%0d: got %h want %h", i, {PSEL, PENABLE, HREADY_OUT, PWDATA},
                 {4'b0100, 1'b1, 1'b0, 32'hAB00_0000});
      end
    end
    step();
    PREADY = 4'b1111;
    #2;
    vectors++;
    if ({HREADY_OUT, HRESP, PENABLE} !== {1'b1, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL wr_done: got %b want %b", {HREADY_OUT, HRESP, PENABLE}, {1'b1, 2'b00, 1'b1});
    end
    step();
    #2;
    vectors++;
    if (PSEL !== 4'b0) begin
      miscompares++;
      $display("FAIL wr_release: got %b want 0000", PSEL);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] addrs [4] = '{32'h4000_0002, 32'h4000_0000, 32'h4000_0001, 32'h4000_0008};
    logic [2:0]  sizes [4] = '{3'd1, 3'd1, 3'd0, 3'd2};
    logic [3:0]  strbs [4] = '{4'b1100, 4'b0011, 4'b0010, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      step();
      addr_phase(addrs[i], 1'b1, sizes[i]);
      #2;
      step();
      bus_idle();
      #2;
      step();
      #2;
      vectors++;
      if ({PSEL, PSTRB} !== {4'b0001, strbs[i]}) begin
        miscompares++;
        $display("FAIL strb%0d: got %b want %b", i, {PSEL, PSTRB}, {4'b0001, strbs[i]});
      end
      step();
      step();
    end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [5] = '{32'h4000_4000, 32'h3FFF_FFFC, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd3};
    for (int i = 0; i < 5; i++) begin
      step();
      addr_phase(addrs[i], 1'b0, sizes[i]);
      #2;
      step();
      bus_idle();
      #2;
      vectors++;
      if ({HREADY_OUT, HRESP, PSEL, PENABLE} !== {1'b0, 2'b01, 4'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL derr_c1_%0d: got %b want %b", i, {HREADY_OUT, HRESP, PSEL, PENABLE},
                 {1'b0, 2'b01, 4'b0, 1'b0});
      end
      step();
      #2;
      vectors++;
      if ({HREADY_OUT, HRESP, PSEL} !== {1'b1, 2'b01, 4'b0}) begin
        miscompares++;
        $display("FAIL derr_c2_%0d: got %b want %b", i, {HREADY_OUT, HRESP, PSEL}, {1'b1, 2'b01, 4'b0});
      end
      step();
      #2;
      vectors++;
      if ({HREADY_OUT, HRESP} !== {1'b1, 2'b00}) begin
        miscompares++;
        $display("FAIL derr_end_%0d: got %b want %b", i, {HREADY_OUT, HRESP}, {1'b1, 2'b00});
      end
    end
  endtask

  task automatic test_no_accept();
    step();
    addr_phase(32'h4000_0000, 1'b0, 3'd2);
    HREADY_IN = 1'b0;
    #2;
    step();
    HTRANS = 2'b01;
    HREADY_IN = 1'b1;
    #2;
    vectors++;
    if ({PSEL, HREADY_OUT, HRESP} !== {4'b0, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL noacc_hready: got %b want %b", {PSEL, HREADY_OUT, HRESP}, {4'b0, 1'b1, 2'b00});
    end
    step();
    bus_idle();
    #2;
    vectors++;
    if ({PSEL, HREADY_OUT, HRESP} !== {4'b0, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL noacc_busy: got %b want %b", {PSEL, HREADY_OUT, HRESP}, {4'b0, 1'b1, 2'b00});
    end
  endtask

  task automatic test_slverr();
    step();
    addr_phase(32'h4000_0010, 1'b0, 3'd2);
    PSLVERR = 4'b0001;
    #2;
    step();
    bus_idle();
    #2;
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA} !== {4'b0001, 1'b1, 1'b0, 2'b01, 32'h0}) begin
      miscompares++;
      $display("FAIL slverr_acc: got %h want %h", {PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA},
               {4'b0001, 1'b1, 1'b0, 2'b01, 32'h0});
    end
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== {4'b0, 1'b0, 1'b1, 2'b01}) begin
      miscompares++;
      $display("FAIL slverr_err2: got %b want %b", {PSEL, PENABLE, HREADY_OUT, HRESP}, {4'b0, 1'b0, 1'b1, 2'b01});
    end
    step();
    PSLVERR = 4'b0000;
    #2;
    vectors++;
    if ({HREADY_OUT, HRESP} !== {1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL slverr_end: got %b want %b", {HREADY_OUT, HRESP}, {1'b1, 2'b00});
    end
  endtask

  task automatic test_timeout();
    int acc_cycles;
    step();
    addr_phase(32'h4000_3000, 1'b0, 3'd2);
    PREADY = 4'b0111;
    #2;
    step();
    bus_idle();
    #2;
    acc_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      #2;
      if (PSEL == 4'b1000 && PENABLE && !HREADY_OUT && HRESP == 2'b00) acc_cycles++;
    end
    vectors++;
    if (acc_cycles !== 16) begin
      miscompares++;
      $display("FAIL to_access: got %0d want 16", acc_cycles);
    end
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== {4'b0, 1'b0, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL to_err1: got %b want %b", {PSEL, PENABLE, HREADY_OUT, HRESP}, {4'b0, 1'b0, 1'b0, 2'b01});
    end
    step();
    #2;
    vectors++;
    if ({HREADY_OUT, HRESP} !== {1'b1, 2'b01}) begin
      miscompares++;
      $display("FAIL to_err2: got %b want %b", {HREADY_OUT, HRESP}, {1'b1, 2'b01});
    end
    PREADY = 4'b1111;
  endtask

  task automatic test_back_to_back();
    step();
    addr_phase(32'h4000_1000, 1'b1, 3'd2);
    #2;
    step();
    bus_idle();
    HWDATA = 32'h1234_5678;
    #2;
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, PSTRB, PWDATA} !== {4'b0010, 1'b0, 4'b1111, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL b2b_wsetup: got %h want %h", {PSEL, PENABLE, PSTRB, PWDATA},
               {4'b0010, 1'b0, 4'b1111, 32'h1234_5678});
    end
    step();
    addr_phase(32'h4000_2006, 1'b0, 3'd1);
    #2;
    vectors++;
    if ({HREADY_OUT, HRESP, PENABLE} !== {1'b1, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_wdone: got %b want %b", {HREADY_OUT, HRESP, PENABLE}, {1'b1, 2'b00, 1'b1});
    end
    step();
    bus_idle();
    #2;
    vectors++;
    if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB} !== {4'b0100, 1'b0, 32'h4000_2006, 1'b0, 4'b0000}) begin
      miscompares++;
      $display("FAIL b2b_rsetup: got %h want %h", {PSEL, PENABLE, PADDR, PWRITE, PSTRB},
               {4'b0100, 1'b0, 32'h4000_2006, 1'b0, 4'b0000});
    end
    step();
    #2;
    vectors++;
    if ({HREADY_OUT, HRDATA} !== {1'b1, 32'h2222_2222}) begin
      miscompares++;
      $display("FAIL b2b_rdone: got %h want %h", {HREADY_OUT, HRDATA}, {1'b1, 32'h2222_2222});
    end
  endtask

  task automatic test_reset_mid();
    step();
    addr_phase(32'h4000_1000, 1'b0, 3'd2);
    PREADY = 4'b1101;
    #2;
    step();
    bus_idle();
    #2;
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT} !== {4'b0010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_acc: got %b want %b", {PSEL, PENABLE, HREADY_OUT}, {4'b0010, 1'b1, 1'b0});
    end
    step();
    HRESET = 1'b1;
    #2;
    step();
    #2;
    vectors++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA} !== {4'b0, 1'b0, 1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL rstmid_ahb: got %h want %h", {PSEL, PENABLE, HREADY_OUT, HRESP, HRDATA},
               {4'b0, 1'b0, 1'b1, 2'b00, 32'h0});
    end
    vectors++;
    if ({PADDR, PWRITE, PSTRB, PWDATA} !== 69'h0) begin
      miscompares++;
      $display("FAIL rstmid_apb: got %h want %h", {PADDR, PWRITE, PSTRB, PWDATA}, 69'h0);
    end
    HRESET = 1'b0;
    PREADY = 4'b1111;
    step();
    #2;
    vectors++;
    if ({PSEL, HREADY_OUT, HRESP} !== {4'b0, 1'b1, 2'b00}) begin
      miscompares++;
      $display("FAIL rstmid_after: got %b want %b", {PSEL, HREADY_OUT, HRESP}, {4'b0, 1'b1, 2'b00});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    HRESET      = 1'b1;
    HBURST      = 3'd0;
    HWDATA      = 32'h0;
    PRDATA      = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
    PREADY      = 4'b1111;
    PSLVERR     = 4'b0000;
    bus_idle();
    test_reset();
    test_read();
    test_write_wait();
    test_strobes();
    test_decode_err();
    test_no_accept();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
